wadd_seq: RTL



---
 rtl/wadd_seq_if.sv | 27 ++
 rtl/wadd_seq.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/wadd_seq_if.sv
// Host-side bus of the word-serial wide adder: request operands in, status and
// registered result out. The master modport is the requester; slave is wadd_seq.
interface wadd_seq_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned WORDS = 4
);
    logic                 start;
    logic                 cin;
    logic [W*WORDS-1:0]   a;
    logic [W*WORDS-1:0]   b;
    logic                 busy;
    logic                 done;
    logic [W*WORDS-1:0]   s;
    logic                 cout;
    logic                 gen;
    logic                 prop;

    modport master (
        output start, cin, a, b,
        input  busy, done, s, cout, gen, prop
    );

    modport slave (
        input  start, cin, a, b,
        output busy, done, s, cout, gen, prop
    );
endinterface

// File: rtl/wadd_seq.sv
// Word-serial wide adder sequencer. Streams W-bit operand slices, least
// significant first, through one external combinational adder slice and
// resolves the inter-slice carry in a local register.
// Optional feature macro: WADD_SEQ_GP_EN builds group generate/propagate
// accumulators; without it gen and prop are tied to 0.
module wadd_seq #(
    parameter int unsigned W     = 8,
    parameter int unsigned WORDS = 4
) (
    input  logic         clk,
    input  logic         rst,
    wadd_seq_if.slave    bus,
    output logic [W-1:0] slice_a,
    output logic [W-1:0] slice_b,
    output logic         slice_cin,
    input  logic [W-1:0] slice_s,
    input  logic         slice_gen,
    input  logic         slice_prop
);

    localparam int unsigned Wide = W * WORDS;
    localparam int unsigned IdxW = $clog2(WORDS);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q, state_d;
    logic              accept;
    logic              last;
    logic [IdxW-1:0]   idx_q;
    logic [Wide-1:0]   op_a_q, op_b_q;
    logic [Wide-1:0]   acc_q;
    logic [Wide-1:0]   acc_nxt;
    logic              carry_q;
    logic              carry_nxt;
    logic [Wide-1:0]   s_q;
    logic              cout_q;

    // Next-state decode; accept marks the edge that captures a new request
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (last) state_d = StDone;
            end
            StDone: begin
                if (bus.start) begin
                    accept  = 1'b1;
                    state_d = StRun;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign last      = (state_q == StRun) && (idx_q == IdxW'(WORDS - 1));
    assign slice_a   = op_a_q[W-1:0];
    assign slice_b   = op_b_q[W-1:0];
    assign slice_cin = carry_q;
    assign carry_nxt = slice_gen | (slice_prop & carry_q);
    // Newest slice enters at the top so the sum ends up aligned after WORDS shifts
    assign acc_nxt   = {slice_s, acc_q[Wide-1:W]};

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Operand shifting, carry resolution and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else if (accept) begin
            idx_q   <= '0;
            op_a_q  <= bus.a;
            op_b_q  <= bus.b;
            carry_q <= bus.cin;
        end else if (state_q == StRun) begin
            idx_q   <= idx_q + IdxW'(1);
            op_a_q  <= op_a_q >> W;
            op_b_q  <= op_b_q >> W;
            acc_q   <= acc_nxt;
            carry_q <= carry_nxt;
            if (last) begin
                s_q    <= acc_nxt;
                cout_q <= carry_nxt;
            end
        end
    end

    assign bus.busy = (state_q == StRun);
    assign bus.done = (state_q == StDone);
    assign bus.s    = s_q;
    assign bus.cout = cout_q;

`ifdef WADD_SEQ_GP_EN
    logic g_q, p_q;
    logic g_nxt, p_nxt;
    logic gen_q, prop_q;

    assign g_nxt = slice_gen | (slice_prop & g_q);
    assign p_nxt = p_q & slice_prop;

    // Group generate/propagate accumulation, independent of the carry-in
    always_ff @(posedge clk) begin
        if (rst) begin
            g_q    <= 1'b0;
            p_q    <= 1'b1;
            gen_q  <= 1'b0;
            prop_q <= 1'b0;
        end else if (accept) begin
            g_q <= 1'b0;
            p_q <= 1'b1;
        end else if (state_q == StRun) begin
            g_q <= g_nxt;
            p_q <= p_nxt;
            if (last) begin
                gen_q  <= g_nxt;
                prop_q <= p_nxt;
            end
        end
    end

    assign bus.gen  = gen_q;
    assign bus.prop = prop_q;
`else
    assign bus.gen  = 1'b0;
    assign bus.prop = 1'b0;
`endif

endmodule
